// File: rtl/l2_cache_pkg.sv
// Shared types and datapath operation codes for the L2 cache controller.
package l2_cache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StWriteback,
    StFetch
  } l2_ctrl_state_t;

  localparam logic [2:0] WCS_IDLE   = 3'b000;
  localparam logic [2:0] WCS_CPU_WR = 3'b100;
  localparam logic [2:0] WCS_WB     = 3'b001;
  localparam logic [2:0] WCS_FETCH  = 3'b011;
  localparam logic [2:0] WCS_FILL   = 3'b111;

  function automatic logic [1:0] way_onehot(input logic way);
    return way ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/l2_perf_counters.sv
// Three saturating event counters for L2 hit, miss and writeback activity.
module l2_perf_counters #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hit_inc,
  input  logic                 miss_inc,
  input  logic                 wb_inc,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  logic [CNT_WIDTH-1:0] hit_q, miss_q, wb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
      wb_q   <= '0;
    end else begin
      // Each counter sticks at all-ones rather than wrapping.
      if (hit_inc && (hit_q != '1))   hit_q  <= hit_q + CNT_WIDTH'(1);
      if (miss_inc && (miss_q != '1)) miss_q <= miss_q + CNT_WIDTH'(1);
      if (wb_inc && (wb_q != '1))     wb_q   <= wb_q + CNT_WIDTH'(1);
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;

endmodule

// File: rtl/l2_cache_control.sv
// Sequencer for the 2-way L2 datapath: hit resolution, dirty writeback and line fill.
// Define L2_PERF_CNT_EN to build the hit/miss/writeback performance counters.
module l2_cache_control
  import l2_cache_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 cacheline_read,
  input  logic                 cacheline_resp,
  input  logic                 HIT,
  input  logic                 way_hit,
  input  logic                 lru_data,
  input  logic [1:0]           valid_out,
  input  logic [1:0]           dirty_out,
  output logic [1:0]           LD_DIRTY,
  output logic                 dirty_in_value,
  output logic                 LD_LRU,
  output logic                 lru_in_value,
  output logic [1:0]           LD_VALID,
  output logic                 valid_in,
  output logic [1:0]           LD_TAG,
  output logic [2:0]           W_CACHE_STATUS,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  l2_ctrl_state_t state_q, state_d;
  logic           victim_dirty;

  assign victim_dirty = valid_out[lru_data] & dirty_out[lru_data];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    mem_resp       = 1'b0;
    cacheline_read = 1'b0;
    LD_DIRTY       = 2'b00;
    dirty_in_value = 1'b0;
    LD_LRU         = 1'b0;
    lru_in_value   = 1'b0;
    LD_VALID       = 2'b00;
    valid_in       = 1'b0;
    LD_TAG         = 2'b00;
    W_CACHE_STATUS = WCS_IDLE;
    unique case (state_q)
      StIdle: begin
        if (mem_read || mem_write) state_d = StCompare;
      end
      StCompare: begin
        if (HIT) begin
          mem_resp     = 1'b1;
          LD_LRU       = 1'b1;
          lru_in_value = ~way_hit;
          // A write wins when both requests are raised.
          if (mem_write) begin
            W_CACHE_STATUS = WCS_CPU_WR;
            LD_DIRTY       = way_onehot(way_hit);
            dirty_in_value = 1'b1;
          end
          state_d = StIdle;
        end else begin
          state_d = victim_dirty ? StWriteback : StFetch;
        end
      end
      StWriteback: begin
        W_CACHE_STATUS = WCS_WB;
        if (cacheline_resp) state_d = StFetch;
      end
      StFetch: begin
        cacheline_read = 1'b1;
        W_CACHE_STATUS = WCS_FETCH;
        // Fill the victim way in the response cycle, then re-compare to finish the access.
        if (cacheline_resp) begin
          W_CACHE_STATUS = WCS_FILL;
          LD_TAG         = way_onehot(lru_data);
          LD_VALID       = way_onehot(lru_data);
          valid_in       = 1'b1;
          LD_DIRTY       = way_onehot(lru_data);
          dirty_in_value = 1'b0;
          state_d        = StCompare;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef L2_PERF_CNT_EN
  // Marks the COMPARE that follows a fill so its hit is not counted.
  logic post_fill_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      post_fill_q <= 1'b0;
    end else if (state_q == StFetch && cacheline_resp) begin
      post_fill_q <= 1'b1;
    end else if (state_q == StCompare) begin
      post_fill_q <= 1'b0;
    end
  end

  l2_perf_counters #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_perf (
    .clk       (clk),
    .rst       (rst),
    .hit_inc   ((state_q == StCompare) && HIT && !post_fill_q),
    .miss_inc  ((state_q == StCompare) && !HIT),
    .wb_inc    ((state_q == StWriteback) && cacheline_resp),
    .hit_count (hit_count),
    .miss_count(miss_count),
    .wb_count  (wb_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_l2_cache_control.sv
// Bench for l2_cache_control: behavioural 2-way set and memory around the DUT, scoreboarded.
module tb_l2_cache_control;
  import l2_cache_pkg::*;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write, mem_resp;
  logic          cacheline_read, cacheline_resp;
  logic          HIT, way_hit, lru_data;
  logic [1:0]    valid_out, dirty_out;
  logic [1:0]    LD_DIRTY, LD_VALID, LD_TAG;
  logic          dirty_in_value, LD_LRU, lru_in_value, valid_in;
  logic [2:0]    W_CACHE_STATUS;
  logic [CW-1:0] hit_count, miss_count, wb_count;

  always #5 clk = ~clk;

  l2_cache_control #(
    .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_resp      (mem_resp),
    .cacheline_read(cacheline_read),
    .cacheline_resp(cacheline_resp),
    .HIT           (HIT),
    .way_hit       (way_hit),
    .lru_data      (lru_data),
    .valid_out     (valid_out),
    .dirty_out     (dirty_out),
    .LD_DIRTY      (LD_DIRTY),
    .dirty_in_value(dirty_in_value),
    .LD_LRU        (LD_LRU),
    .lru_in_value  (lru_in_value),
    .LD_VALID      (LD_VALID),
    .valid_in      (valid_in),
    .LD_TAG        (LD_TAG),
    .W_CACHE_STATUS(W_CACHE_STATUS),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .wb_count      (wb_count)
  );

  // Single-set datapath model reacting to the DUT's load enables.
  logic       dp_clr;
  logic [1:0] dp_valid, dp_dirty;
  logic       dp_lru;
  logic [7:0] dp_tag [2];
  logic [7:0] req_tag;

  always_ff @(posedge clk) begin
    if (dp_clr) begin
      dp_valid  <= '0;
      dp_dirty  <= '0;
      dp_lru    <= 1'b0;
      dp_tag[0] <= '0;
      dp_tag[1] <= '0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (LD_TAG[w])   dp_tag[w]   <= req_tag;
        if (LD_VALID[w]) dp_valid[w] <= valid_in;
        if (LD_DIRTY[w]) dp_dirty[w] <= dirty_in_value;
      end
      if (LD_LRU) dp_lru <= lru_in_value;
    end
  end

  assign HIT       = (dp_valid[0] && dp_tag[0] == req_tag) || (dp_valid[1] && dp_tag[1] == req_tag);
  assign way_hit   = dp_valid[1] && dp_tag[1] == req_tag;
  assign lru_data  = dp_lru;
  assign valid_out = dp_valid;
  assign dirty_out = dp_dirty;

  // Memory model: answers after mem_lat cycles of a WB or FETCH request.
  int         mem_lat;
  logic [7:0] mem_cnt;
  logic       mem_active;

  assign mem_active     = cacheline_read || (W_CACHE_STATUS == WCS_WB);
  assign cacheline_resp = (mem_cnt == 8'(mem_lat - 1));

  always_ff @(posedge clk) begin
    if (dp_clr || !mem_active || cacheline_resp) mem_cnt <= '0;
    else                                         mem_cnt <= mem_cnt + 8'd1;
  end

  typedef struct {
    int lat;
    int rd;
    int wb;
    bit way;
    bit wr;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   exp_hit    = 0;
  int   exp_miss   = 0;
  int   exp_wb     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  task automatic check_counters();
    int eh, em, ew;
`ifdef L2_PERF_CNT_EN
    eh = exp_hit;
    em = exp_miss;
    ew = exp_wb;
`else
    eh = 0;
    em = 0;
    ew = 0;
`endif
    check_eq("hit_count", 32'(hit_count), eh);
    check_eq("miss_count", 32'(miss_count), em);
    check_eq("wb_count", 32'(wb_count), ew);
  endtask

  task automatic run_txn(input logic [7:0] tag, input bit rd, input bit wr);
    exp_t e, got_e;
    bit   hit, hw, vdirty;
    bit   done = 1'b0;
    int   cycles = 0;
    int   rdc = 0;
    int   wbc = 0;
    hit    = (dp_valid[0] && dp_tag[0] == tag) || (dp_valid[1] && dp_tag[1] == tag);
    hw     = dp_valid[1] && dp_tag[1] == tag;
    vdirty = dp_valid[dp_lru] && dp_dirty[dp_lru];
    e.way  = hit ? hw : dp_lru;
    e.wr   = wr;
    e.rd   = hit ? 0 : mem_lat;
    e.wb   = (!hit && vdirty) ? mem_lat : 0;
    e.lat  = hit ? 1 : 2 + e.rd + e.wb;
    sb.push_back(e);
    if (hit) exp_hit = sat_inc(exp_hit);
    else begin
      exp_miss = sat_inc(exp_miss);
      if (vdirty) exp_wb = sat_inc(exp_wb);
    end
    req_tag   = tag;
    mem_read  = rd;
    mem_write = wr;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (cacheline_read) rdc++;
      if (W_CACHE_STATUS == WCS_WB) wbc++;
      if (cycles == 1 && !hit)
        check_eq("miss_no_loads", {LD_TAG, LD_VALID, LD_DIRTY, LD_LRU, mem_resp}, 0);
      if (cacheline_read && cacheline_resp) begin
        check_eq("fill_status", W_CACHE_STATUS, WCS_FILL);
        check_eq("fill_loads", {LD_TAG, LD_VALID, LD_DIRTY}, {3{way_onehot(e.way)}});
        check_eq("fill_values", {valid_in, dirty_in_value}, 2'b10);
      end
      if (mem_resp) begin
        done  = 1'b1;
        got_e = sb.pop_front();
        check_eq("latency", cycles, got_e.lat);
        check_eq("read_cycles", rdc, got_e.rd);
        check_eq("wb_cycles", wbc, got_e.wb);
        check_eq("lru_update", {LD_LRU, lru_in_value}, {1'b1, ~got_e.way});
        check_eq("hit_no_fill", {LD_TAG, LD_VALID}, 0);
        if (got_e.wr)
          check_eq("write_merge", {W_CACHE_STATUS, LD_DIRTY, dirty_in_value},
                   {WCS_CPU_WR, way_onehot(got_e.way), 1'b1});
        else
          check_eq("read_quiet", {W_CACHE_STATUS, LD_DIRTY}, 0);
      end
    end
    if (!done) begin
      check_eq("resp_timeout", done, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check_eq("resp_pulse", {mem_resp, W_CACHE_STATUS, cacheline_read}, 0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    req_tag   = 8'h00;
    mem_lat   = 5;
    dp_clr    = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_eq("reset_outputs", {mem_resp, cacheline_read, W_CACHE_STATUS, LD_TAG, LD_VALID,
                               LD_DIRTY, LD_LRU}, 0);
    check_counters();
    repeat (2) @(negedge clk);
    dp_clr = 1'b0;
    rst    = 1'b1;

    run_txn(8'h3A, 1'b1, 1'b0);  // clean miss into way 0
    check_counters();
    run_txn(8'h3A, 1'b1, 1'b0);  // read hit
    check_counters();
    run_txn(8'h3B, 1'b1, 1'b0);  // clean miss into way 1
    run_txn(8'h3B, 1'b0, 1'b1);  // write hit way 1
    run_txn(8'h3A, 1'b1, 1'b1);  // both raised: write hit way 0
    run_txn(8'h3B, 1'b1, 1'b0);  // read hit, LRU back to way 0
    mem_lat = 3;
    run_txn(8'h3C, 1'b1, 1'b0);  // dirty victim way 0
    check_counters();
    mem_lat = 5;

    // Abandon a dirty miss while it is fetching.
    req_tag  = 8'h3D;
    mem_read = 1'b1;
    n = 0;
    while (!cacheline_read && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_fetch", cacheline_read, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_outputs", {mem_resp, cacheline_read, W_CACHE_STATUS, LD_TAG, LD_VALID,
                               LD_DIRTY, LD_LRU}, 0);
    exp_hit  = 0;
    exp_miss = 0;
    exp_wb   = 0;
    check_counters();
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_txn(8'h3D, 1'b1, 1'b0);  // dirty miss after reset
    check_counters();
    for (int i = 0; i < 20; i++) run_txn(8'h3D, 1'b1, 1'b0);
    check_counters();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
